fwft_small_fifo: RTL and testbench

// - Small first-word-fall-through FIFO for shallow side-queues beside the datapath
//   (e.g. parsed-header descriptor queues feeding output-queue logic).
// - The head word is presented on dout whenever empty is low; rd_en pops it. No read latency.
// - Single clock domain; register-array storage; depth 2**MAX_DEPTH_BITS.

---
 rtl/fwft_small_fifo.sv | 84 ++++++++
 tb/tb_fwft_small_fifo.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/fwft_small_fifo.sv
// Shallow first-word-fall-through FIFO: head word is visible on dout whenever empty is low.
// Optional simulation checks for overflow/underflow are compiled in with FWFT_FIFO_ERR_CHECK_EN.
module fwft_small_fifo #(
   parameter int WIDTH               = 72,
   parameter int MAX_DEPTH_BITS      = 3,
   parameter int PROG_FULL_THRESHOLD = 2**MAX_DEPTH_BITS - 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   input  logic             wr_en,
   input  logic             rd_en,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             nearly_full,
   output logic             empty
);

   localparam int MAX_DEPTH = 2**MAX_DEPTH_BITS;
   localparam logic [MAX_DEPTH_BITS:0] FULL_LVL      = {1'b1, {MAX_DEPTH_BITS{1'b0}}};
   localparam logic [MAX_DEPTH_BITS:0] PROG_FULL_LVL = PROG_FULL_THRESHOLD[MAX_DEPTH_BITS:0];

   logic [WIDTH-1:0]          mem [MAX_DEPTH];
   logic [MAX_DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
   logic [MAX_DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
   logic [MAX_DEPTH_BITS:0]   depth_q,  depth_d;
   logic                      wr_fire;
   logic                      rd_fire;

   // A write into a full FIFO is still taken when the head is popped on the same edge.
   assign wr_fire = wr_en && (!full || rd_en);
   assign rd_fire = rd_en && !empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      depth_d  = depth_q;
      if (wr_fire) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_fire) rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({wr_fire, rd_fire})
         2'b10:   depth_d = depth_q + 1'b1;
         2'b01:   depth_d = depth_q - 1'b1;
         default: depth_d = depth_q;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         depth_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         depth_q  <= depth_d;
      end
   end

   // NOTE: storage has no reset; contents are meaningless until written and dout is don't-care while empty.
   always_ff @(posedge clk) begin
      if (wr_fire) mem[wr_ptr_q] <= din;
   end

   assign dout        = mem[rd_ptr_q];
   assign empty       = (depth_q == '0);
   assign full        = (depth_q == FULL_LVL);
   assign nearly_full = (depth_q >= PROG_FULL_LVL);

`ifdef FWFT_FIFO_ERR_CHECK_EN
   always @(posedge clk) begin
      if (reset && wr_en && full && !rd_en) begin
         $display("%t %m ERROR: write to full fifo", $time);
         $stop;
      end
      if (reset && rd_en && empty) begin
         $display("%t %m ERROR: read from empty fifo", $time);
         $stop;
      end
   end
`else
`endif

endmodule

// File: tb/tb_fwft_small_fifo.sv
// Scoreboard bench for fwft_small_fifo at default parameters (depth 8, nearly_full at 7).
module tb_fwft_small_fifo;

   localparam int W = 72;
   localparam int D = 8;

   logic         clk;
   logic         reset;
   logic [W-1:0] din;
   logic         wr_en;
   logic         rd_en;
   logic [W-1:0] dout;
   logic         full;
   logic         nearly_full;
   logic         empty;

   logic [W-1:0] sb [$];
   int           n_cmp;
   int           n_err;

   fwft_small_fifo dut (
      .clk         (clk),
      .reset       (reset),
      .din         (din),
      .wr_en       (wr_en),
      .rd_en       (rd_en),
      .dout        (dout),
      .full        (full),
      .nearly_full (nearly_full),
      .empty       (empty)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Drives one clock edge and applies the same acceptance rules to the scoreboard.
   task automatic drive_edge(input logic wr, input logic rd, input logic [W-1:0] data);
      bit wr_acc;
      bit rd_acc;
      wr_acc = wr && (sb.size() < D || rd);
      rd_acc = rd && (sb.size() > 0);
      wr_en  = wr;
      rd_en  = rd;
      din    = data;
      @(posedge clk);
      #1;
      wr_en = 1'b0;
      rd_en = 1'b0;
      if (rd_acc) void'(sb.pop_front());
      if (wr_acc) sb.push_back(data);
   endtask

   task automatic test_reset();
      reset = 1'b0;
      #12;
      n_cmp++; if (empty !== 1'b1)       begin n_err++; $display("FAIL reset_empty got=%b exp=1", empty); end
      n_cmp++; if (full !== 1'b0)        begin n_err++; $display("FAIL reset_full got=%b exp=0", full); end
      n_cmp++; if (nearly_full !== 1'b0) begin n_err++; $display("FAIL reset_nearly_full got=%b exp=0", nearly_full); end
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      drive_edge(1'b1, 1'b0, 72'hA5);
      n_cmp++; if (empty !== 1'b0)  begin n_err++; $display("FAIL first_write_empty got=%b exp=0", empty); end
      n_cmp++; if (dout !== 72'hA5) begin n_err++; $display("FAIL first_write_dout got=%h exp=%h", dout, 72'hA5); end
      drive_edge(1'b0, 1'b1, '0);
      n_cmp++; if (empty !== 1'b1)  begin n_err++; $display("FAIL first_pop_empty got=%b exp=1", empty); end
   endtask

   task automatic test_fill();
      for (int i = 1; i <= D; i++) begin
         drive_edge(1'b1, 1'b0, W'(i));
         n_cmp++; if (nearly_full !== (i >= 7)) begin n_err++; $display("FAIL fill_nearly_full[%0d] got=%b exp=%b", i, nearly_full, i >= 7); end
         n_cmp++; if (full !== (i == D))        begin n_err++; $display("FAIL fill_full[%0d] got=%b exp=%b", i, full, i == D); end
      end
      drive_edge(1'b1, 1'b0, W'(99));
      n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL overflow_full got=%b exp=1", full); end
      for (int i = 1; i <= D; i++) begin
         n_cmp++; if (dout !== sb[0]) begin n_err++; $display("FAIL fill_pop_data[%0d] got=%h exp=%h", i, dout, sb[0]); end
         n_cmp++; if (dout !== W'(i)) begin n_err++; $display("FAIL fill_pop_order[%0d] got=%h exp=%h", i, dout, W'(i)); end
         drive_edge(1'b0, 1'b1, '0);
         n_cmp++; if (empty !== (i == D)) begin n_err++; $display("FAIL drain_empty[%0d] got=%b exp=%b", i, empty, i == D); end
      end
   endtask

   task automatic test_simultaneous();
      logic [W-1:0] last;
      for (int i = 0; i < 4; i++) drive_edge(1'b1, 1'b0, W'(32'h100 + i));
      drive_edge(1'b1, 1'b1, W'(32'h200));
      n_cmp++; if (dout !== 72'h101) begin n_err++; $display("FAIL both_mid_dout got=%h exp=%h", dout, 72'h101); end
      n_cmp++; if (sb.size() != 4 || empty !== 1'b0 || nearly_full !== 1'b0)
         begin n_err++; $display("FAIL both_mid_flags got=e%b nf%b exp=e0 nf0", empty, nearly_full); end
      while (sb.size() > 0) begin
         n_cmp++; if (dout !== sb[0]) begin n_err++; $display("FAIL both_mid_drain got=%h exp=%h", dout, sb[0]); end
         drive_edge(1'b0, 1'b1, '0);
      end
      for (int i = 0; i < D; i++) drive_edge(1'b1, 1'b0, W'(32'h280 + i));
      drive_edge(1'b1, 1'b1, W'(32'h300));
      n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL both_full_full got=%b exp=1", full); end
      last = '0;
      while (sb.size() > 0) begin
         n_cmp++; if (dout !== sb[0]) begin n_err++; $display("FAIL both_full_drain got=%h exp=%h", dout, sb[0]); end
         last = dout;
         drive_edge(1'b0, 1'b1, '0);
      end
      n_cmp++; if (last !== 72'h300) begin n_err++; $display("FAIL both_full_last got=%h exp=%h", last, 72'h300); end
      drive_edge(1'b1, 1'b1, W'(32'h400));
      n_cmp++; if (empty !== 1'b0)   begin n_err++; $display("FAIL both_empty_empty got=%b exp=0", empty); end
      n_cmp++; if (dout !== 72'h400) begin n_err++; $display("FAIL both_empty_dout got=%h exp=%h", dout, 72'h400); end
      drive_edge(1'b0, 1'b1, '0);
      n_cmp++; if (empty !== 1'b1)   begin n_err++; $display("FAIL both_empty_pop got=%b exp=1", empty); end
   endtask

   task automatic test_wrap();
      logic [W-1:0] exp_next;
      int           pushed;
      exp_next = W'(32'h1000);
      pushed   = 0;
      for (int i = 0; i < 3; i++) begin drive_edge(1'b1, 1'b0, W'(32'h1000 + pushed)); pushed++; end
      for (int c = 0; c < 20; c++) begin
         if (c % 2 == 0) begin
            drive_edge(1'b1, 1'b0, W'(32'h1000 + pushed));
            pushed++;
         end else begin
            n_cmp++; if (dout !== sb[0] || dout !== exp_next)
               begin n_err++; $display("FAIL wrap_pop[%0d] got=%h exp=%h", c, dout, exp_next); end
            exp_next++;
            drive_edge(1'b0, 1'b1, '0);
         end
      end
      while (sb.size() > 0) begin
         n_cmp++; if (dout !== exp_next) begin n_err++; $display("FAIL wrap_drain got=%h exp=%h", dout, exp_next); end
         exp_next++;
         drive_edge(1'b0, 1'b1, '0);
      end
      n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL wrap_end_empty got=%b exp=1", empty); end
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 5; i++) drive_edge(1'b1, 1'b0, W'(32'h2000 + i));
      @(negedge clk);
      #2;
      reset = 1'b0;
      #1;
      n_cmp++; if (empty !== 1'b1)       begin n_err++; $display("FAIL async_rst_empty got=%b exp=1", empty); end
      n_cmp++; if (full !== 1'b0)        begin n_err++; $display("FAIL async_rst_full got=%b exp=0", full); end
      n_cmp++; if (nearly_full !== 1'b0) begin n_err++; $display("FAIL async_rst_nearly_full got=%b exp=0", nearly_full); end
      sb.delete();
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      drive_edge(1'b1, 1'b0, W'(32'h55));
      drive_edge(1'b1, 1'b0, W'(32'h56));
      n_cmp++; if (dout !== 72'h55) begin n_err++; $display("FAIL post_rst_dout got=%h exp=%h", dout, 72'h55); end
      drive_edge(1'b0, 1'b1, '0);
      n_cmp++; if (dout !== 72'h56) begin n_err++; $display("FAIL post_rst_second got=%h exp=%h", dout, 72'h56); end
      drive_edge(1'b0, 1'b1, '0);
      n_cmp++; if (empty !== 1'b1)  begin n_err++; $display("FAIL post_rst_empty got=%b exp=1", empty); end
   endtask

   task automatic test_empty_pop();
      drive_edge(1'b0, 1'b1, '0);
      drive_edge(1'b0, 1'b1, '0);
      n_cmp++; if (empty !== 1'b1 || full !== 1'b0 || nearly_full !== 1'b0)
         begin n_err++; $display("FAIL underflow_flags got=e%b f%b nf%b exp=e1 f0 nf0", empty, full, nearly_full); end
      drive_edge(1'b1, 1'b0, W'(32'h77));
      n_cmp++; if (dout !== 72'h77 || empty !== 1'b0)
         begin n_err++; $display("FAIL underflow_recover got=%h e%b exp=%h e0", dout, empty, 72'h77); end
      drive_edge(1'b0, 1'b1, '0);
      n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL underflow_final_empty got=%b exp=1", empty); end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      reset = 1'b0;
      wr_en = 1'b0;
      rd_en = 1'b0;
      din   = '0;
      test_reset();
      test_fill();
      test_simultaneous();
      test_wrap();
      test_async_reset();
      test_empty_pop();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
